pixels_header_seq: RTL and testbench



---
 rtl/pixels_header_seq.sv | 214 +++++++++++++++++++++
 tb/tb_pixels_header_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixels_header_seq.sv
// Header/payload sequencer for the pixel-stream unpacker: queues per-layer descriptors, emits one
// configuration header beat per layer, then forwards exactly the programmed number of DMA beats.
module pixels_header_seq #(
  parameter int unsigned ROWS              = 8,
  parameter int unsigned KH_MAX            = 11,
  parameter int unsigned CI_MAX            = 2048,
  parameter int unsigned XW_MAX            = 512,
  parameter int unsigned XH_MAX            = 512,
  parameter int unsigned WORD_WIDTH        = 8,
  parameter int unsigned S_PIXELS_WIDTH_LF = 64,
  parameter int unsigned DESC_DEPTH        = 4,
  localparam int unsigned BITS_KH2 = $clog2((KH_MAX + 1) / 2),
  localparam int unsigned BITS_CI  = $clog2(CI_MAX),
  localparam int unsigned BITS_XW  = $clog2(XW_MAX),
  localparam int unsigned BITS_L   = $clog2(XH_MAX / ROWS),
  localparam int unsigned KEEP_W   = S_PIXELS_WIDTH_LF / WORD_WIDTH
) (
  input  logic                         aclk,
  input  logic                         rst,
  // descriptor queue
  input  logic                         desc_valid,
  output logic                         desc_ready,
  input  logic [BITS_KH2-1:0]          desc_kh2,
  input  logic [BITS_CI-1:0]           desc_ci,
  input  logic [BITS_XW-1:0]           desc_w,
  input  logic [BITS_L-1:0]            desc_l,
  input  logic [31:0]                  desc_beats,
  // DMA payload
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_last,
  input  logic [S_PIXELS_WIDTH_LF-1:0] s_data,
  input  logic [KEEP_W-1:0]            s_keep,
  // stream to unpacker
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [S_PIXELS_WIDTH_LF-1:0] m_data,
  output logic [KEEP_W-1:0]            m_keep,
  // status
  output logic                         busy,
  output logic                         done,
  output logic                         err_len,
  input  logic                         err_clr
);

  localparam int unsigned HDR_W = BITS_KH2 + BITS_CI + BITS_XW + BITS_L;
  localparam int unsigned PTR_W = $clog2(DESC_DEPTH);

  if (S_PIXELS_WIDTH_LF < HDR_W) begin : gen_chk_width
    $error("stream too narrow for the configuration header");
  end
  if (DESC_DEPTH < 2 || (DESC_DEPTH & (DESC_DEPTH - 1)) != 0) begin : gen_chk_depth
    $error("DESC_DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [31:0]          beats;
    logic [BITS_L-1:0]    l;
    logic [BITS_XW-1:0]   w;
    logic [BITS_CI-1:0]   ci;
    logic [BITS_KH2-1:0]  kh2;
  } desc_t;

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StDrain} state_e;

  localparam logic [PTR_W:0] PtrOne = 1;

  // ---------------------------------------------------------------------------
  // Descriptor FIFO: pointers carry one wrap bit to tell full from empty
  // ---------------------------------------------------------------------------
  desc_t          mem_q [DESC_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic           fifo_full, fifo_empty;
  logic           push, pop;
  desc_t          wr_desc, head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign desc_ready = !fifo_full;
  assign push       = desc_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_desc       = '0;
    wr_desc.beats = desc_beats;
    wr_desc.l     = desc_l;
    wr_desc.w     = desc_w;
    wr_desc.ci    = desc_ci;
    wr_desc.kh2   = desc_kh2;
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_desc;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // ---------------------------------------------------------------------------
  // Layer sequencer
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  desc_t       act_q, act_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d, err_set;
  logic [HDR_W-1:0] hdr;

  assign hdr = {act_q.l, act_q.w, act_q.ci, act_q.kh2};

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    beat_cnt_d = beat_cnt_q;
    err_set    = 1'b0;
    done       = 1'b0;
    pop        = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_data     = '0;
    m_keep     = '0;
    s_ready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          act_d      = head;
          beat_cnt_d = head.beats;
          if (head.beats == 32'd0) begin
            // Zero-length layer: flag it and retire without touching the stream.
            err_set = 1'b1;
            done    = 1'b1;
          end else begin
            state_d = StHdr;
          end
        end
      end

      StHdr: begin
        m_valid            = 1'b1;
        m_data[HDR_W-1:0]  = hdr;
        m_keep             = '1;
        if (m_ready) state_d = StPay;
      end

      StPay: begin
        m_valid = s_valid;
        s_ready = m_ready;
        m_data  = s_data;
        m_keep  = s_keep;
        m_last  = (beat_cnt_q == 32'd1) || s_last;
        if (s_valid && m_ready) begin
          beat_cnt_d = beat_cnt_q - 32'd1;
          if (beat_cnt_q == 32'd1) begin
            if (s_last) begin
              done    = 1'b1;
              state_d = StIdle;
            end else begin
              // DMA still has data for this layer; swallow it up to its s_last.
              err_set = 1'b1;
              state_d = StDrain;
            end
          end else if (s_last) begin
            err_set = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StDrain: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Clear beats a same-cycle set.
  assign err_d = err_clr ? 1'b0 : (err_q | err_set);

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      act_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign err_len = err_q;

endmodule

// File: tb/tb_pixels_header_seq.sv
// Directed bench for pixels_header_seq: normal, back-pressured, short/long DMA, illegal length,
// FIFO-full chaining and mid-transfer reset, all checked against hand-built expected beats.
module tb_pixels_header_seq;

  logic        aclk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [2:0]  desc_kh2;
  logic [10:0] desc_ci;
  logic [8:0]  desc_w;
  logic [5:0]  desc_l;
  logic [31:0] desc_beats;
  logic        s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        busy, done, err_len, err_clr;

  pixels_header_seq dut (
    .aclk       (aclk),
    .rst        (rst),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_kh2   (desc_kh2),
    .desc_ci    (desc_ci),
    .desc_w     (desc_w),
    .desc_l     (desc_l),
    .desc_beats (desc_beats),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_last     (s_last),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len),
    .err_clr    (err_clr)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink ready: always 1, or a stall pattern with a guaranteed stall every third cycle.
  bit bp_mode = 1'b0;
  int bp_cyc  = 0;
  always @(posedge aclk) begin
    #1;
    bp_cyc++;
    if (!bp_mode)            m_ready = 1'b1;
    else if (bp_cyc % 3 == 0) m_ready = 1'b0;
    else                      m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: sampled mid-cycle, so a visible handshake completes at the next rising edge.
  logic [72:0] out_q[$];
  logic [72:0] exp_q[$];
  int          done_cnt = 0;
  int          drop_cnt = 0;
  int          hold_bad = 0;
  int          hold_seen = 0;
  bit          hold_pending = 1'b0;
  logic [72:0] hold_val;

  always @(negedge aclk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (m_valid && m_ready) out_q.push_back({m_last, m_keep, m_data});
      if (done) done_cnt++;
      if (s_valid && s_ready && !m_valid) drop_cnt++;
      if (hold_pending) begin
        hold_seen++;
        if ({m_valid, m_keep, m_data} !== hold_val) hold_bad++;
      end
      hold_pending = m_valid && !m_ready;
      hold_val     = {1'b1, m_keep, m_data};
    end
  end

  int cmp_idx = 0;

  task automatic compare_out(input string tag);
    check({tag, "_count"}, out_q.size(), exp_q.size());
    for (int k = cmp_idx; k < exp_q.size(); k++) begin
      if (k < out_q.size()) check($sformatf("%s_beat%0d", tag, k), out_q[k], exp_q[k]);
    end
    cmp_idx = exp_q.size();
  endtask

  function automatic logic [63:0] hdr(input int kh2, input int ci, input int w, input int l);
    return (64'(l) << 23) | (64'(w) << 14) | (64'(ci) << 3) | 64'(kh2);
  endfunction

  task automatic exp_push(input bit last, input logic [7:0] keep, input logic [63:0] data);
    exp_q.push_back({last, keep, data});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_desc(input int kh2, input int ci, input int w, input int l, input int beats);
    bit ok = 1'b0;
    desc_valid = 1'b1;
    desc_kh2   = 3'(kh2);
    desc_ci    = 11'(ci);
    desc_w     = 9'(w);
    desc_l     = 6'(l);
    desc_beats = 32'(beats);
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (desc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    desc_valid = 1'b0;
    if (!ok) check("desc_push_timeout", 0, 1);
  endtask

  // Sends beats 1..n with data base+i; s_last on beat last_at (0 = never).
  task automatic send_dma(input int n, input int last_at, input logic [63:0] base,
                          input logic [7:0] keep);
    for (int i = 1; i <= n; i++) begin
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_data  = base + 64'(i);
      s_keep  = keep;
      s_last  = (i == last_at);
      for (int c = 0; c < 200; c++) begin
        @(negedge aclk);
        if (s_ready) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge aclk);
      #1;
      if (!ok) check("dma_beat_timeout", 0, 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int d0, drop0;

  initial begin
    rst = 1'b1; desc_valid = 1'b0; desc_kh2 = '0; desc_ci = '0; desc_w = '0; desc_l = '0;
    desc_beats = '0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; err_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge aclk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_desc_ready", desc_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_len, 0);
    @(posedge aclk);
    #1 rst = 1'b0;

    // Normal layer: header 8437777 = 1 | 2<<3 | 3<<14 | 1<<23
    d0 = done_cnt;
    push_desc(1, 2, 3, 1, 5);
    @(posedge aclk);
    #1;
    check("t1_hdr_latency_valid", m_valid, 1);
    check("t1_hdr_latency_data", m_data, 64'd8437777);
    exp_push(1'b0, 8'hFF, 64'd8437777);
    for (int i = 1; i <= 5; i++) exp_push(i == 5, 8'hFF, 64'hA100_0000_0000_0000 + 64'(i));
    send_dma(5, 5, 64'hA100_0000_0000_0000, 8'hFF);
    idle(3);
    compare_out("t1");
    check("t1_done", done_cnt - d0, 1);
    check("t1_err", err_len, 0);
    check("t1_busy", busy, 0);

    // Back-pressure
    bp_mode = 1'b1;
    d0 = done_cnt;
    push_desc(1, 2, 3, 1, 5);
    exp_push(1'b0, 8'hFF, 64'd8437777);
    for (int i = 1; i <= 5; i++) exp_push(i == 5, 8'h0F, 64'hA200_0000_0000_0000 + 64'(i));
    send_dma(5, 5, 64'hA200_0000_0000_0000, 8'h0F);
    idle(3);
    bp_mode = 1'b0;
    idle(2);
    compare_out("t2");
    check("t2_done", done_cnt - d0, 1);
    check("t2_hold_stable", hold_bad, 0);
    check("t2_stall_seen", hold_seen != 0, 1);

    // Short DMA: 8 programmed, s_last on 5
    d0 = done_cnt;
    push_desc(2, 100, 50, 3, 8);
    exp_push(1'b0, 8'hFF, hdr(2, 100, 50, 3));
    for (int i = 1; i <= 5; i++) exp_push(i == 5, 8'h3C, 64'hA300_0000_0000_0000 + 64'(i));
    send_dma(5, 5, 64'hA300_0000_0000_0000, 8'h3C);
    idle(3);
    compare_out("t3");
    check("t3_done", done_cnt - d0, 1);
    check("t3_err", err_len, 1);
    check("t3_busy", busy, 0);
    d0 = done_cnt;
    push_desc(3, 7, 9, 2, 2);
    exp_push(1'b0, 8'hFF, hdr(3, 7, 9, 2));
    for (int i = 1; i <= 2; i++) exp_push(i == 2, 8'hF0, 64'hA400_0000_0000_0000 + 64'(i));
    send_dma(2, 2, 64'hA400_0000_0000_0000, 8'hF0);
    idle(3);
    compare_out("t3_next");
    check("t3_next_done", done_cnt - d0, 1);
    check("t3_err_sticky", err_len, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t3_err_clr", err_len, 0);

    // Long DMA: 4 programmed, s_last on 7
    d0 = done_cnt;
    drop0 = drop_cnt;
    push_desc(4, 1, 2, 5, 4);
    exp_push(1'b0, 8'hFF, hdr(4, 1, 2, 5));
    for (int i = 1; i <= 4; i++) exp_push(i == 4, 8'hFF, 64'hA500_0000_0000_0000 + 64'(i));
    send_dma(7, 7, 64'hA500_0000_0000_0000, 8'hFF);
    idle(3);
    compare_out("t4");
    check("t4_dropped", drop_cnt - drop0, 3);
    check("t4_done", done_cnt - d0, 1);
    check("t4_err", err_len, 1);
    check("t4_busy", busy, 0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t4_err_clr", err_len, 0);

    // Zero-length descriptor with err_clr held: clear wins
    d0 = done_cnt;
    err_clr = 1'b1;
    push_desc(1, 1, 1, 1, 0);
    idle(3);
    err_clr = 1'b0;
    check("t5_clr_wins_err", err_len, 0);
    check("t5_clr_wins_done", done_cnt - d0, 1);
    d0 = done_cnt;
    push_desc(1, 1, 1, 1, 0);
    idle(3);
    check("t5_illegal_err", err_len, 1);
    check("t5_illegal_done", done_cnt - d0, 1);
    check("t5_illegal_busy", busy, 0);
    compare_out("t5");
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;

    // FIFO full with DMA stalled, then chain all five layers
    d0 = done_cnt;
    for (int k = 1; k <= 5; k++) push_desc(k, 10 * k, 20 * k, k, k);
    @(negedge aclk);
    check("t6_full_after5", desc_ready, 0);
    desc_valid = 1'b1;
    desc_beats = 32'd1;
    repeat (3) @(negedge aclk);
    check("t6_still_full", desc_ready, 0);
    @(posedge aclk);
    #1 desc_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_push(1'b0, 8'hFF, hdr(k, 10 * k, 20 * k, k));
      for (int i = 1; i <= k; i++)
        exp_push(i == k, 8'h55, 64'hA600_0000_0000_0000 + (64'(k) << 8) + 64'(i));
      send_dma(k, k, 64'hA600_0000_0000_0000 + (64'(k) << 8), 8'h55);
    end
    idle(4);
    compare_out("t6");
    check("t6_done", done_cnt - d0, 5);
    check("t6_err", err_len, 0);
    check("t6_desc_ready", desc_ready, 1);
    check("t6_busy", busy, 0);

    // Reset mid-payload, with a second descriptor queued
    push_desc(5, 5, 5, 5, 6);
    push_desc(6, 6, 6, 6, 3);
    exp_push(1'b0, 8'hFF, hdr(5, 5, 5, 5));
    for (int i = 1; i <= 2; i++) exp_push(1'b0, 8'hFF, 64'hA700_0000_0000_0000 + 64'(i));
    send_dma(2, 0, 64'hA700_0000_0000_0000, 8'hFF);
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 64'hDEAD_BEEF_0000_0001;
    s_keep  = 8'hFF;
    #1;
    check("t7_pre_m_valid", m_valid, 1);
    check("t7_pre_m_last", m_last, 1);
    rst = 1'b1;
    #1;
    check("t7_rst_m_valid", m_valid, 0);
    check("t7_rst_m_last", m_last, 0);
    check("t7_rst_m_data", m_data, 0);
    check("t7_rst_m_keep", m_keep, 0);
    check("t7_rst_s_ready", s_ready, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_desc_ready", desc_ready, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge aclk);
    #1 rst = 1'b0;
    idle(5);
    check("t7_fifo_flushed", busy, 0);
    check("t7_err", err_len, 0);
    compare_out("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
